id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register and operand-select stage directly upstream of the ALU.
- Accepts decoded instructions from decode and resolves each source operand from one of three places: register file, EX/WB forwarding paths, or the immediate.
- Registers alu input0/input1/control plus destination info for writeback, using a valid/ready handshake.
- Inserts a one-cycle bubble on load-use hazards and supports flush on taken branch or jump.

Parameters:
- C_WIDTH, 4, ALU control/opcode width
- D_WIDTH, 34, datapath width
- R_WIDTH, 4, register address width
- I_WIDTH, 16, immediate field width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage accepts this cycle
- in_opcode  in  C_WIDTH  opcode, same encoding as ALU control (MUL=1, ADD=2, SUB=3, OR=4, NOR=5, SR=6, LW=7, SW=8, BNE=9, BEQ=10, SLT=11, J=12, SET=13, SL=14, QUIT=15)
- in_rs_addr, in_rt_addr, in_rd_addr  in  R_WIDTH each  source and destination registers
- in_rs_data, in_rt_data  in  D_WIDTH each  register file read data
- in_imm  in  I_WIDTH  immediate
- in_use_imm  in  1  input1 takes the immediate instead of rt
- in_wb_en  in  1  instruction writes rd
- fwd_ex_en  in  1  instruction in EX writes a register
- fwd_ex_addr  in  R_WIDTH  EX destination register
- fwd_ex_data  in  D_WIDTH  ALU result
- fwd_ex_is_load  in  1  EX instruction is LW (data not yet available)
- fwd_wb_en  in  1  WB writes a register
- fwd_wb_addr  in  R_WIDTH  WB destination register
- fwd_wb_data  in  D_WIDTH  WB data
- flush  in  1  kill the held and incoming instruction
- out_valid  out  1  registered outputs are valid
- out_ready  in  1  ALU/EX stage consumes
- alu_input0, alu_input1  out  D_WIDTH each  ALU operands
- alu_control  out  C_WIDTH  ALU control
- out_rt_data  out  D_WIDTH  store data for SW (forwarded rt)
- out_rd_addr  out  R_WIDTH  destination register
- out_wb_en  out  1  destination write enable
- bubble_count  out  16  count of load-use bubbles inserted, saturating

Behaviour:
- Reset (rst_n=0 at posedge):
  - out_valid=0, out_wb_en=0, bubble_count=0.
  - alu_input0, alu_input1, out_rt_data=0; alu_control=0; out_rd_addr=0.
  - Reset takes priority over flush and any handshake.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Outputs hold stable while out_valid && !out_ready.
- Hazard:
  - Asserted when in_valid && fwd_ex_en && fwd_ex_is_load && fwd_ex_addr!=0.
  - Applies when fwd_ex_addr matches in_rs_addr, or matches in_rt_addr while (!in_use_imm || opcode==SW).
  - While hazard holds and downstream drains: out_valid is driven to 0 for that cycle (bubble) and bubble_count increments, saturating at 16'hFFFF.
  - The instruction is accepted on a later cycle, once hazard is 0.
- Forwarding, applied per source, combinationally at the accept cycle:
  - Address 0 always reads 0.
  - EX match (fwd_ex_en, not load) has priority over WB match.
  - WB match has priority over register file data.
- Operand select:
  - alu_input0 = forwarded rs.
  - alu_input1 = in_use_imm ? ext(imm) : forwarded rt.
  - ext() sign-extends for ADD, SUB, SLT, LW, SW, BEQ, BNE; zero-extends for all other opcodes.
  - out_rt_data = forwarded rt, always.
- Latency: exactly one cycle from accept to out_valid.
- Flush:
  - At posedge, sets out_valid=0 and out_wb_en=0.
  - Discards any incoming instruction; in_ready=0 that cycle.
  - Flush during a hazard cancels the pending stall with no bubble_count increment.
- Simultaneous consume and accept (out_ready=1, in_valid=1, no hazard): the new instruction replaces the old with no gap. Full throughput is 1 instruction per cycle.
- out_wb_en is forced 0 when rd_addr==0.

Test Plan:
- Reset then single ADD: rs=r1 (data 5), rt=r2 (data 7), in_use_imm=0 -> next cycle out_valid=1, input0=5, input1=7, control=2.
- EX forward plus sign-extension: fwd_ex r1=0x10 (not load), ADDI imm=16'hFFFF on rs=r1, rf r1=3 -> input0=0x10, input1=34'h3FFFFFFFF. Repeat with OR -> input1=0xFFFF.
- Load-use: fwd_ex_is_load r3, in rs=r3 -> in_ready=0 and one bubble (out_valid=0), bubble_count=1. Next cycle (EX no longer load, WB r3=0x2A) -> accepted with input0=0x2A.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Release -> back-to-back transfers at 1 per cycle.
- Flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0, incoming instruction dropped. Forwarding to r0 -> operand 0, out_wb_en=0.
- Assert rst_n=0 mid-stall with bubble_count=5 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves rs/rt from the register file, the EX/WB
// forwarding paths or the immediate, stalls on load-use and drops work on flush.
module id_ex_fwd #(
  parameter int D_WIDTH = 34,
  parameter int R_WIDTH = 4
) (
  input  logic [R_WIDTH-1:0] addr_i,
  input  logic [D_WIDTH-1:0] rf_data_i,
  input  logic               ex_en_i,
  input  logic               ex_is_load_i,
  input  logic [R_WIDTH-1:0] ex_addr_i,
  input  logic [D_WIDTH-1:0] ex_data_i,
  input  logic               wb_en_i,
  input  logic [R_WIDTH-1:0] wb_addr_i,
  input  logic [D_WIDTH-1:0] wb_data_i,
  output logic [D_WIDTH-1:0] data_o
);
  // A load in EX has no data yet; the hazard stall covers that case instead.
  always_comb begin
    data_o = rf_data_i;
    if (addr_i == '0)                                          data_o = '0;
    else if (ex_en_i && !ex_is_load_i && ex_addr_i == addr_i)  data_o = ex_data_i;
    else if (wb_en_i && wb_addr_i == addr_i)                   data_o = wb_data_i;
  end
endmodule

module id_ex_stage #(
  parameter int C_WIDTH = 4,
  parameter int D_WIDTH = 34,
  parameter int R_WIDTH = 4,
  parameter int I_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C_WIDTH-1:0] in_opcode,
  input  logic [R_WIDTH-1:0] in_rs_addr,
  input  logic [R_WIDTH-1:0] in_rt_addr,
  input  logic [R_WIDTH-1:0] in_rd_addr,
  input  logic [D_WIDTH-1:0] in_rs_data,
  input  logic [D_WIDTH-1:0] in_rt_data,
  input  logic [I_WIDTH-1:0] in_imm,
  input  logic               in_use_imm,
  input  logic               in_wb_en,
  input  logic               fwd_ex_en,
  input  logic [R_WIDTH-1:0] fwd_ex_addr,
  input  logic [D_WIDTH-1:0] fwd_ex_data,
  input  logic               fwd_ex_is_load,
  input  logic               fwd_wb_en,
  input  logic [R_WIDTH-1:0] fwd_wb_addr,
  input  logic [D_WIDTH-1:0] fwd_wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] alu_input0,
  output logic [D_WIDTH-1:0] alu_input1,
  output logic [C_WIDTH-1:0] alu_control,
  output logic [D_WIDTH-1:0] out_rt_data,
  output logic [R_WIDTH-1:0] out_rd_addr,
  output logic               out_wb_en,
  output logic [15:0]        bubble_count
);
  localparam logic [C_WIDTH-1:0] OP_ADD = C_WIDTH'(2);
  localparam logic [C_WIDTH-1:0] OP_SUB = C_WIDTH'(3);
  localparam logic [C_WIDTH-1:0] OP_LW  = C_WIDTH'(7);
  localparam logic [C_WIDTH-1:0] OP_SW  = C_WIDTH'(8);
  localparam logic [C_WIDTH-1:0] OP_BNE = C_WIDTH'(9);
  localparam logic [C_WIDTH-1:0] OP_BEQ = C_WIDTH'(10);
  localparam logic [C_WIDTH-1:0] OP_SLT = C_WIDTH'(11);

  // Source 0 = rs, source 1 = rt.
  logic [1:0][R_WIDTH-1:0] src_addr;
  logic [1:0][D_WIDTH-1:0] src_rf;
  logic [1:0][D_WIDTH-1:0] src_fwd;

  assign src_addr = {in_rt_addr, in_rs_addr};
  assign src_rf   = {in_rt_data, in_rs_data};

  for (genvar s = 0; s < 2; s++) begin : g_src
    id_ex_fwd #(.D_WIDTH(D_WIDTH), .R_WIDTH(R_WIDTH)) u_fwd (
      .addr_i       (src_addr[s]),
      .rf_data_i    (src_rf[s]),
      .ex_en_i      (fwd_ex_en),
      .ex_is_load_i (fwd_ex_is_load),
      .ex_addr_i    (fwd_ex_addr),
      .ex_data_i    (fwd_ex_data),
      .wb_en_i      (fwd_wb_en),
      .wb_addr_i    (fwd_wb_addr),
      .wb_data_i    (fwd_wb_data),
      .data_o       (src_fwd[s])
    );
  end

  logic               valid_q, valid_d;
  logic [D_WIDTH-1:0] in0_q, in0_d, in1_q, in1_d, rt_q, rt_d;
  logic [C_WIDTH-1:0] ctl_q, ctl_d;
  logic [R_WIDTH-1:0] rd_q, rd_d;
  logic               wb_q, wb_d;
  logic [15:0]        bub_q, bub_d;

  logic               rt_used, hazard, drain, accept, sext;
  logic [D_WIDTH-1:0] imm_ext;

  // rt is a real source unless replaced by the immediate; SW still stores rt.
  assign rt_used  = !in_use_imm || (in_opcode == OP_SW);
  assign hazard   = in_valid && fwd_ex_en && fwd_ex_is_load && (fwd_ex_addr != '0) &&
                    ((fwd_ex_addr == in_rs_addr) || (rt_used && fwd_ex_addr == in_rt_addr));
  assign drain    = !valid_q || out_ready;
  assign in_ready = drain && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    case (in_opcode)
      OP_ADD, OP_SUB, OP_SLT, OP_LW, OP_SW, OP_BEQ, OP_BNE: sext = 1'b1;
      default:                                              sext = 1'b0;
    endcase
    imm_ext = {{(D_WIDTH-I_WIDTH){sext & in_imm[I_WIDTH-1]}}, in_imm};
  end

  always_comb begin
    valid_d = valid_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    rt_d    = rt_q;
    ctl_d   = ctl_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    bub_d   = bub_q;
    if (flush) begin
      valid_d = 1'b0;
      wb_d    = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      in0_d   = src_fwd[0];
      in1_d   = in_use_imm ? imm_ext : src_fwd[1];
      rt_d    = src_fwd[1];
      ctl_d   = in_opcode;
      rd_d    = in_rd_addr;
      wb_d    = in_wb_en && (in_rd_addr != '0);
    end else if (drain) begin
      valid_d = 1'b0;
      wb_d    = 1'b0;
      if (hazard && bub_q != 16'hFFFF) bub_d = bub_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      in0_q   <= '0;
      in1_q   <= '0;
      rt_q    <= '0;
      ctl_q   <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      bub_q   <= '0;
    end else begin
      valid_q <= valid_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      rt_q    <= rt_d;
      ctl_q   <= ctl_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      bub_q   <= bub_d;
    end
  end

  assign out_valid    = valid_q;
  assign alu_input0   = in0_q;
  assign alu_input1   = in1_q;
  assign alu_control  = ctl_q;
  assign out_rt_data  = rt_q;
  assign out_rd_addr  = rd_q;
  assign out_wb_en    = wb_q;
  assign bubble_count = bub_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expected ALU-side results queue up as
// instructions are accepted and are compared whenever the stage presents output.
module tb_id_ex_stage;
  logic        clk, rst_n;
  logic        in_valid, in_ready, in_use_imm, in_wb_en;
  logic [3:0]  in_opcode, in_rs_addr, in_rt_addr, in_rd_addr;
  logic [33:0] in_rs_data, in_rt_data;
  logic [15:0] in_imm;
  logic        fwd_ex_en, fwd_ex_is_load, fwd_wb_en, flush;
  logic [3:0]  fwd_ex_addr, fwd_wb_addr;
  logic [33:0] fwd_ex_data, fwd_wb_data;
  logic        out_valid, out_ready, out_wb_en;
  logic [33:0] alu_input0, alu_input1, out_rt_data;
  logic [3:0]  alu_control, out_rd_addr;
  logic [15:0] bubble_count;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rd_addr(in_rd_addr), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_wb_en(in_wb_en),
    .fwd_ex_en(fwd_ex_en), .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
    .fwd_ex_is_load(fwd_ex_is_load), .fwd_wb_en(fwd_wb_en), .fwd_wb_addr(fwd_wb_addr),
    .fwd_wb_data(fwd_wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_input0(alu_input0), .alu_input1(alu_input1),
    .alu_control(alu_control), .out_rt_data(out_rt_data), .out_rd_addr(out_rd_addr),
    .out_wb_en(out_wb_en), .bubble_count(bubble_count)
  );

  typedef struct {
    logic [33:0] in0;
    logic [33:0] in1;
    logic [3:0]  ctl;
    logic [33:0] rt;
    logic [3:0]  rd;
    logic        wb;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  int   n_chk = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    in_valid = 0; in_opcode = 0; in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
    in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_use_imm = 0; in_wb_en = 0;
    fwd_ex_en = 0; fwd_ex_addr = 0; fwd_ex_data = 0; fwd_ex_is_load = 0;
    fwd_wb_en = 0; fwd_wb_addr = 0; fwd_wb_data = 0; flush = 0;
  endtask

  task automatic drv(input logic [3:0] op, input logic [3:0] rs, input logic [33:0] rsd,
                     input logic [3:0] rt, input logic [33:0] rtd, input logic [3:0] rd,
                     input logic [15:0] imm, input logic use_imm);
    in_valid = 1; in_opcode = op; in_rs_addr = rs; in_rs_data = rsd;
    in_rt_addr = rt; in_rt_data = rtd; in_rd_addr = rd; in_imm = imm;
    in_use_imm = use_imm; in_wb_en = 1;
  endtask

  task automatic chk_rdy(input logic exp);
    #1;
    chk("in_ready", in_ready, exp);
  endtask

  // One clock: record accept/consume/kill before the edge, compare after it.
  task automatic cyc();
    logic consume, kill;
    exp_t e;
    #1;
    consume = out_valid && out_ready;
    kill    = flush && out_valid && !out_ready;
    if (rst_n && in_valid && in_ready) sb.push_back(pend);
    @(posedge clk);
    if (!rst_n) sb.delete();
    else if ((consume || kill) && sb.size() > 0) e = sb.pop_front();
    #1;
    chk("out_valid", out_valid, sb.size() != 0);
    if (out_valid && sb.size() != 0) begin
      e = sb[0];
      chk("alu_input0", alu_input0, e.in0);
      chk("alu_input1", alu_input1, e.in1);
      chk("alu_control", alu_control, e.ctl);
      chk("out_rt_data", out_rt_data, e.rt);
      chk("out_rd_addr", out_rd_addr, e.rd);
      chk("out_wb_en", out_wb_en, e.wb);
    end
  endtask

  initial begin
    clr();
    rst_n = 0; out_ready = 1;
    cyc(); cyc();
    chk("rst_in0", alu_input0, 0);
    chk("rst_in1", alu_input1, 0);
    chk("rst_ctl", alu_control, 0);
    chk("rst_rt", out_rt_data, 0);
    chk("rst_rd", out_rd_addr, 0);
    chk("rst_wb", out_wb_en, 0);
    chk("rst_bub", bubble_count, 0);
    rst_n = 1;

    // plain ADD from the register file
    drv(4'd2, 4'd1, 34'd5, 4'd2, 34'd7, 4'd3, 16'h0, 1'b0);
    pend = '{in0: 34'd5, in1: 34'd7, ctl: 4'd2, rt: 34'd7, rd: 4'd3, wb: 1'b1};
    chk_rdy(1);
    cyc();

    // EX forward on rs, immediate sign- vs zero-extension, back to back
    drv(4'd2, 4'd1, 34'd3, 4'd5, 34'd9, 4'd4, 16'hFFFF, 1'b1);
    fwd_ex_en = 1; fwd_ex_addr = 4'd1; fwd_ex_data = 34'h10;
    pend = '{in0: 34'h10, in1: 34'h3FFFFFFFF, ctl: 4'd2, rt: 34'd9, rd: 4'd4, wb: 1'b1};
    cyc();
    in_opcode = 4'd4;
    pend = '{in0: 34'h10, in1: 34'h0FFFF, ctl: 4'd4, rt: 34'd9, rd: 4'd4, wb: 1'b1};
    cyc();

    // load-use on rs: one bubble, then WB supplies the value
    clr();
    drv(4'd2, 4'd3, 34'd1, 4'd0, 34'd0, 4'd5, 16'h0, 1'b0);
    fwd_ex_en = 1; fwd_ex_addr = 4'd3; fwd_ex_is_load = 1;
    chk_rdy(0);
    cyc();
    chk("bubble_1", bubble_count, 1);
    fwd_ex_en = 0; fwd_ex_is_load = 0;
    fwd_wb_en = 1; fwd_wb_addr = 4'd3; fwd_wb_data = 34'h2A;
    pend = '{in0: 34'h2A, in1: 34'd0, ctl: 4'd2, rt: 34'd0, rd: 4'd5, wb: 1'b1};
    chk_rdy(1);
    cyc();

    // SW with immediate still depends on rt; flush during the stall does not count
    clr();
    drv(4'd8, 4'd0, 34'd0, 4'd4, 34'h44, 4'd6, 16'h5, 1'b1);
    fwd_ex_en = 1; fwd_ex_addr = 4'd4; fwd_ex_is_load = 1;
    chk_rdy(0);
    cyc();
    chk("bubble_sw", bubble_count, 2);
    flush = 1;
    chk_rdy(0);
    cyc();
    chk("bubble_flush", bubble_count, 2);
    flush = 0;
    in_opcode = 4'd2;
    pend = '{in0: 34'd0, in1: 34'd5, ctl: 4'd2, rt: 34'h44, rd: 4'd6, wb: 1'b1};
    chk_rdy(1);
    cyc();

    // backpressure: A held for 3 cycles while B waits, then B and C stream
    clr();
    drv(4'd3, 4'd6, 34'd100, 4'd7, 34'd30, 4'd8, 16'h0, 1'b0);
    pend = '{in0: 34'd100, in1: 34'd30, ctl: 4'd3, rt: 34'd30, rd: 4'd8, wb: 1'b1};
    cyc();
    out_ready = 0;
    drv(4'd2, 4'd1, 34'd1, 4'd2, 34'd2, 4'd9, 16'h0, 1'b0);
    pend = '{in0: 34'd1, in1: 34'd2, ctl: 4'd2, rt: 34'd2, rd: 4'd9, wb: 1'b1};
    for (int i = 0; i < 3; i++) begin
      chk_rdy(0);
      cyc();
    end
    out_ready = 1;
    chk_rdy(1);
    cyc();
    drv(4'd5, 4'd1, 34'h123456789, 4'd2, 34'd7, 4'd10, 16'h8000, 1'b1);
    pend = '{in0: 34'h123456789, in1: 34'h08000, ctl: 4'd5, rt: 34'd7, rd: 4'd10, wb: 1'b1};
    chk_rdy(1);
    cyc();
    clr();
    cyc();

    // flush kills the held output and the incoming instruction
    drv(4'd2, 4'd1, 34'd11, 4'd2, 34'd22, 4'd3, 16'h0, 1'b0);
    pend = '{in0: 34'd11, in1: 34'd22, ctl: 4'd2, rt: 34'd22, rd: 4'd3, wb: 1'b1};
    cyc();
    out_ready = 0; flush = 1;
    drv(4'd3, 4'd4, 34'd44, 4'd5, 34'd55, 4'd6, 16'h0, 1'b0);
    chk_rdy(0);
    cyc();
    clr();
    out_ready = 1;
    cyc();

    // r0 never forwards and never writes back
    drv(4'd2, 4'd0, 34'h77, 4'd0, 34'h88, 4'd0, 16'h0, 1'b0);
    fwd_ex_en = 1; fwd_ex_addr = 4'd0; fwd_ex_data = 34'h55;
    fwd_wb_en = 1; fwd_wb_addr = 4'd0; fwd_wb_data = 34'h66;
    pend = '{in0: 34'd0, in1: 34'd0, ctl: 4'd2, rt: 34'd0, rd: 4'd0, wb: 1'b0};
    cyc();

    // EX beats WB beats register file
    clr();
    drv(4'd2, 4'd2, 34'hE, 4'd3, 34'hC, 4'd7, 16'h0, 1'b0);
    fwd_ex_en = 1; fwd_ex_addr = 4'd2; fwd_ex_data = 34'hA;
    fwd_wb_en = 1; fwd_wb_addr = 4'd2; fwd_wb_data = 34'hB;
    pend = '{in0: 34'hA, in1: 34'hC, ctl: 4'd2, rt: 34'hC, rd: 4'd7, wb: 1'b1};
    cyc();

    // reset in the middle of a stall
    clr();
    drv(4'd2, 4'd5, 34'd1, 4'd0, 34'd0, 4'd8, 16'h0, 1'b0);
    fwd_ex_en = 1; fwd_ex_addr = 4'd5; fwd_ex_is_load = 1;
    for (int i = 0; i < 3; i++) cyc();
    chk("bubble_5", bubble_count, 5);
    rst_n = 0;
    cyc();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_bub", bubble_count, 0);
    chk("mid_rst_in0", alu_input0, 0);
    chk("mid_rst_in1", alu_input1, 0);
    chk("mid_rst_ctl", alu_control, 0);
    chk("mid_rst_rd", out_rd_addr, 0);
    chk("mid_rst_wb", out_wb_en, 0);
    rst_n = 1;
    clr();
    cyc();
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
